// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO-to-stream read path: FSM states, the default
// sample width and the beat layout used by the frame reader.
package fifo_stream_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAME_LEN  = 64;
    localparam int DEF_IDX_W      = $clog2(DEF_FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Beat layout at the default configuration; the reader builds the same
    // shape with its own parameter widths.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      last;
        logic [DEF_IDX_W-1:0]      index;
    } sample_beat_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry circular buffer that absorbs downstream backpressure; the head
// entry is presented directly from storage.
module stream_skid_buf #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_occ;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout = r_mem[r_rptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the async FIFO read port and re-emits samples as FRAME_LEN-sample
// frames on a valid/ready stream tagged with index, last and a frame count.
module fifo_frame_reader
    import fifo_stream_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int FRAME_LEN  = 64,
    parameter  int FCNT_W     = 16,
    localparam int IDX_W      = $clog2(FRAME_LEN)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [IDX_W-1:0]      m_index,
    output logic [FCNT_W-1:0]     frame_count,
    output logic                  busy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [IDX_W-1:0]      index;
    } beat_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e              r_state;
    state_e              w_next;
    logic                r_inflight;
    logic [IDX_W-1:0]    r_rd_idx;
    logic [IDX_W-1:0]    r_infl_idx;
    logic [FCNT_W-1:0]   r_frame_count;
    logic [1:0]          w_occ;
    logic                w_pop;
    logic                w_slot_free;
    logic                w_reads_left;
    beat_t               w_in;
    beat_t               w_head;

    assign w_pop = (w_occ != 2'd0) && m_ready;

    // A pop in this cycle frees a slot for the read issued now, which is what
    // lets a 2-entry buffer sustain one sample per cycle.
    assign w_slot_free = (3'(w_occ) + 3'(r_inflight)) <= (3'(w_pop) + 3'd1);

    // Mid-frame reads always continue; a new frame starts only while enabled.
    assign w_reads_left = (r_rd_idx != '0) || ((r_state == RUN) && enable);

    assign fifo_rd_en = ((r_state == RUN) || (r_state == FINISH)) && !fifo_empty
                        && w_slot_free && w_reads_left;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_next = RUN;
            RUN:     if (!enable) w_next = (r_rd_idx != '0) ? FINISH : IDLE;
            FINISH: begin
                if (enable)                               w_next = RUN;
                else if ((r_rd_idx == '0) && !r_inflight) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state       <= IDLE;
            r_inflight    <= 1'b0;
            r_rd_idx      <= '0;
            r_frame_count <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= fifo_rd_en;
            if (fifo_rd_en)
                r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
            if (w_pop && w_head.last)
                r_frame_count <= r_frame_count + FCNT_W'(1);
        end
    end

    // Index of the read in flight; paired with fifo_rd_data one cycle later.
    always_ff @(posedge rd_clk) begin
        if (fifo_rd_en) r_infl_idx <= r_rd_idx;
    end

    always_comb begin
        w_in       = '0;
        w_in.data  = fifo_rd_data;
        w_in.last  = (r_infl_idx == LAST_IDX);
        w_in.index = r_infl_idx;
    end

    stream_skid_buf #(
        .W ($bits(beat_t))
    ) u_buf (
        .i_clk  (rd_clk),
        .i_rst  (rd_rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_din  (w_in),
        .o_dout (w_head),
        .o_occ  (w_occ)
    );

    // Outputs read zero whenever the buffer is empty.
    assign m_valid     = (w_occ != 2'd0);
    assign m_data      = m_valid ? w_head.data  : '0;
    assign m_last      = m_valid ? w_head.last  : 1'b0;
    assign m_index     = m_valid ? w_head.index : '0;
    assign frame_count = r_frame_count;
    assign busy        = (r_state != IDLE) || m_valid;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a queue-backed FIFO model feeds the
// reader, expected beats are queued at stimulus time and popped by a monitor.
module tb_fifo_frame_reader;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic [1:0]  i;
    } ent_t;

    logic        clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_rd_data = 16'd0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic [1:0]  m_index;
    logic [15:0] frame_count;
    logic        busy;

    logic        rst2 = 1'b1;
    logic        enable2 = 1'b0;
    logic        fifo_rd_en2;
    logic [15:0] fifo_rd_data2 = 16'd0;
    logic [15:0] ctr2 = 16'd0;
    logic [15:0] m_data2;
    logic        m_valid2;
    logic        m_last2;
    logic [0:0]  m_index2;
    logic [7:0]  frame_count2;
    logic        busy2;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   occ_m = 0;
    int   infl_m = 0;
    int   rd_count = 0;
    int   exp2 = 0;
    bit   saw_wrap = 0;
    logic [15:0] fq[$];
    ent_t        eq[$];
    int          acc_cyc[$];

    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;
    logic [15:0] prev_d = 16'd0;
    logic [1:0]  prev_i = 2'd0;
    ent_t        e;

    always #5 clk = ~clk;

    fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(4), .FCNT_W(16)) u_dut (
        .rd_clk(clk), .rd_rst(rd_rst), .enable(enable), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_index(m_index),
        .frame_count(frame_count), .busy(busy)
    );

    fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(2), .FCNT_W(8)) u_dut2 (
        .rd_clk(clk), .rd_rst(rst2), .enable(enable2), .fifo_rd_en(fifo_rd_en2),
        .fifo_empty(1'b0), .fifo_rd_data(fifo_rd_data2), .m_data(m_data2),
        .m_valid(m_valid2), .m_ready(1'b1), .m_last(m_last2), .m_index(m_index2),
        .frame_count(frame_count2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input int d, input int idx, input bit expect_out);
        fq.push_back(16'(d));
        if (expect_out) eq.push_back('{d: 16'(d), l: (idx == 3), i: 2'(idx)});
    endtask

    // mode 0: drained and FIFO empty; mode 1: scoreboard empty and DUT idle
    task automatic wait_done(input string name, input int mode, input int budget);
        int k;
        bit done;
        k = 0;
        done = 0;
        while (k < budget && !done) begin
            @(posedge clk); #1;
            k++;
            if (mode == 0) done = (eq.size() == 0) && (fq.size() == 0) && !m_valid;
            else           done = (eq.size() == 0) && !busy;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, %0d beats outstanding", name, budget, eq.size());
        end
    endtask

    // FIFO model: registered empty flag, data valid the cycle after the read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fq.pop_front();
            rd_count     <= rd_count + 1;
        end
        fifo_empty <= (fq.size() == 0);
    end

    always @(posedge clk) begin
        if (rd_rst) begin
            occ_m  <= 0;
            infl_m <= 0;
        end else begin
            infl_m <= (fifo_rd_en && !fifo_empty) ? 1 : 0;
            occ_m  <= occ_m + infl_m - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            default: m_ready = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        if (rst2) ctr2 <= 16'd0;
        else if (fifo_rd_en2) begin
            fifo_rd_data2 <= ctr2;
            ctr2          <= ctr2 + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (!rd_rst) begin
            if (fifo_rd_en) chk("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
            chk("valid_vs_occ", {31'd0, m_valid}, {31'd0, occ_m != 0});
            if (occ_m + infl_m == 2 && !(m_valid && m_ready))
                chk("rd_en_when_full", {31'd0, fifo_rd_en}, 32'd0);
            if (prev_v && !prev_r && !prev_rst) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {16'd0, m_data}, {16'd0, prev_d});
                chk("hold_last", {31'd0, m_last}, {31'd0, prev_l});
                chk("hold_index", {30'd0, m_index}, {30'd0, prev_i});
            end
            if (m_valid && m_ready) begin
                n_chk++;
                if (eq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h index %0d, none required", m_data, m_index);
                end else begin
                    e = eq.pop_front();
                    chk("beat_data", {16'd0, m_data}, {16'd0, e.d});
                    chk("beat_last", {31'd0, m_last}, {31'd0, e.l});
                    chk("beat_index", {30'd0, m_index}, {30'd0, e.i});
                    acc_cyc.push_back(cyc);
                end
            end
        end
        prev_v   = m_valid;
        prev_r   = m_ready;
        prev_d   = m_data;
        prev_l   = m_last;
        prev_i   = m_index;
        prev_rst = rd_rst;
    end

    // Second instance: endless FIFO with an incrementing pattern, FRAME_LEN=2.
    always @(negedge clk) begin
        if (!rst2) begin
            chk("t6_fcnt", {24'd0, frame_count2}, {24'd0, 8'(exp2 / 2)});
            if (exp2 / 2 == 256) begin
                chk("t6_wrap", {24'd0, frame_count2}, 32'd0);
                saw_wrap = 1;
            end
            if (m_valid2) begin
                chk("t6_data", {16'd0, m_data2}, 32'(16'(exp2)));
                chk("t6_index", {31'd0, m_index2}, {31'd0, exp2[0]});
                chk("t6_last", {31'd0, m_last2}, {31'd0, exp2[0]});
                exp2++;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_count}, 32'd0);
        @(posedge clk); #1;
        rd_rst  = 1'b0;
        rst2    = 1'b0;
        enable2 = 1'b1;

        // Two back-to-back frames at full rate
        for (int i = 0; i < 8; i++) push_word(i, i % 4, 1);
        acc_cyc.delete();
        enable = 1'b1;
        wait_done("t1_drain", 0, 200);
        chk("t1_beats", acc_cyc.size(), 32'd8);
        if (acc_cyc.size() == 8) chk("t1_consecutive", acc_cyc[7] - acc_cyc[0], 32'd7);
        chk("t1_fcnt", {16'd0, frame_count}, 32'd2);

        // Backpressure pattern 1,0,0
        ready_mode = 1;
        for (int i = 0; i < 4; i++) push_word(8 + i, i, 1);
        wait_done("t2_drain", 0, 200);
        ready_mode = 0;
        chk("t2_fcnt", {16'd0, frame_count}, 32'd3);

        // FIFO runs dry mid-frame
        push_word(20, 0, 1);
        push_word(21, 1, 1);
        wait_done("t3_first_half", 0, 100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t3_rd_en_idle", {31'd0, fifo_rd_en}, 32'd0);
        chk("t3_no_valid", {31'd0, m_valid}, 32'd0);
        chk("t3_fcnt_mid", {16'd0, frame_count}, 32'd3);
        @(posedge clk); #1;
        push_word(22, 2, 1);
        push_word(23, 3, 1);
        wait_done("t3_second_half", 0, 100);
        chk("t3_fcnt", {16'd0, frame_count}, 32'd4);

        // Disable after index 1: finish the frame only
        push_word(30, 0, 1);
        push_word(31, 1, 1);
        wait_done("t4_first_half", 0, 100);
        enable = 1'b0;
        rd_count = rd_count;
        begin
            int base;
            base = rd_count;
            push_word(32, 2, 1);
            push_word(33, 3, 1);
            for (int i = 0; i < 3; i++) push_word(34 + i, 0, 0);
            wait_done("t4_idle", 1, 100);
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("t4_reads", rd_count - base, 32'd2);
        end
        chk("t4_fifo_left", fq.size(), 32'd3);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_fcnt", {16'd0, frame_count}, 32'd5);
        @(posedge clk); #1;
        fq.delete();

        // Reset mid-frame with the buffer full
        ready_mode = 2;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push_word(40 + i, i, 0);
        begin
            int k;
            k = 0;
            while (k < 30 && occ_m != 2) begin
                @(posedge clk); #1;
                k++;
            end
            chk("t5_full_reached", occ_m, 32'd2);
        end
        rd_rst = 1'b1;
        fq.delete();
        eq.delete();
        @(posedge clk); #1;
        rd_rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_data", {16'd0, m_data}, 32'd0);
        chk("t5_last", {31'd0, m_last}, 32'd0);
        chk("t5_index", {30'd0, m_index}, 32'd0);
        chk("t5_fcnt", {16'd0, frame_count}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(posedge clk); #1;
        ready_mode = 0;
        for (int i = 0; i < 4; i++) push_word(50 + i, i, 1);
        wait_done("t5_restart", 0, 100);
        chk("t5_fcnt_after", {16'd0, frame_count}, 32'd1);

        // Frame-counter wrap on the FRAME_LEN=2 instance
        begin
            int k;
            k = 0;
            while (k < 2000 && exp2 < 2 * 260) begin
                @(posedge clk); #1;
                k++;
            end
            enable2 = 1'b0;
            chk("t6_frames_run", {31'd0, exp2 >= 2 * 260}, 32'd1);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t6_saw_wrap", {31'd0, saw_wrap}, 32'd1);
        chk("t6_busy_end", {31'd0, busy2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
